exponent_bit_streamer: RTL and testbench

Serializes a BITS_IN_EXP-bit exponent into the one-bit-per-consume stream that the Montgomery accumulator reads on its n_bit_in / consumed_n_out interface.
- Accepts the exponent as REGISTER_SIZE-bit blocks, least-significant block first, over a valid/ready handshake.
- Presents the current exponent bit continuously, LSB first.
- Advances one bit per single-cycle consume pulse from the accumulator.
- Sits between the exponent source (randomness/message path) and the accumulator; supports replay of the same exponent without reloading.

---
 rtl/exponent_bit_streamer.sv | 128 ++++++++++++
 tb/tb_exponent_bit_streamer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exponent_bit_streamer.sv
// Exponent bit streamer: loads an exponent block-by-block (LSB block first) and
// presents it one bit at a time, LSB first, advancing on each consume pulse.
// The stored exponent can be replayed from bit 0 without reloading.
module exponent_bit_streamer #(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned BITS_IN_EXP   = 2048
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [REGISTER_SIZE-1:0]       block_in,
    input  logic                           block_valid_in,
    output logic                           block_ready_out,
    input  logic                           consumed_bit_in,
    input  logic                           restart_in,
    output logic                           bit_out,
    output logic                           bit_valid_out,
    output logic [$clog2(BITS_IN_EXP)-1:0] bit_idx_out,
    output logic                           last_bit_out,
    output logic                           done_out
);

    localparam int unsigned BLOCKS = BITS_IN_EXP / REGISTER_SIZE;
    localparam int unsigned IDX_W  = $clog2(BITS_IN_EXP);
    localparam int unsigned WR_W   = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS_IN_EXP - 1);
    localparam logic [WR_W-1:0]  LAST_BLK = WR_W'(BLOCKS - 1);

    typedef enum logic [1:0] {
        StLoad,
        StStream,
        StDone
    } state_e;

    state_e                   r_state;
    logic [WR_W-1:0]          r_wr_idx;
    logic [IDX_W-1:0]         r_bit_idx;
    logic                     r_block_ready;
    logic                     r_bit_valid;
    logic                     r_done;
    // Block b occupies bits [b*REGISTER_SIZE +: REGISTER_SIZE], so bit_idx indexes it directly.
    logic [BITS_IN_EXP-1:0]   r_exp;

    logic                     w_accept;
    logic                     w_streaming;

    assign w_accept    = block_valid_in && r_block_ready;
    assign w_streaming = (r_state == StStream);

    // Block storage: each word captures block_in when it is the write target of a handshake.
    for (genvar b = 0; b < BLOCKS; b++) begin : g_blk
        always_ff @(posedge clk_in) begin
            if (w_accept && (r_wr_idx == WR_W'(b))) begin
                r_exp[b*REGISTER_SIZE +: REGISTER_SIZE] <= block_in;
            end
        end
    end

    // Control FSM: load blocks, stream bits, one-cycle done with optional replay.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state       <= StLoad;
            r_wr_idx      <= '0;
            r_bit_idx     <= '0;
            r_block_ready <= 1'b1;
            r_bit_valid   <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            unique case (r_state)
                StLoad: begin
                    if (w_accept) begin
                        if (r_wr_idx == LAST_BLK) begin
                            r_wr_idx      <= '0;
                            r_bit_idx     <= '0;
                            r_state       <= StStream;
                            r_block_ready <= 1'b0;
                            r_bit_valid   <= 1'b1;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                StStream: begin
                    // Restart wins over a simultaneous consume.
                    if (restart_in) begin
                        r_bit_idx <= '0;
                    end else if (consumed_bit_in) begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_bit_idx   <= '0;
                            r_state     <= StDone;
                            r_bit_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_done <= 1'b0;
                    if (restart_in) begin
                        r_bit_idx   <= '0;
                        r_state     <= StStream;
                        r_bit_valid <= 1'b1;
                    end else begin
                        r_state       <= StLoad;
                        r_block_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= StLoad;
                    r_wr_idx      <= '0;
                    r_bit_idx     <= '0;
                    r_block_ready <= 1'b1;
                    r_bit_valid   <= 1'b0;
                    r_done        <= 1'b0;
                end
            endcase
        end
    end

    assign block_ready_out = r_block_ready;
    assign bit_valid_out   = r_bit_valid;
    assign done_out        = r_done;
    assign bit_idx_out     = r_bit_idx;
    assign bit_out         = w_streaming && r_exp[r_bit_idx];
    assign last_bit_out    = w_streaming && (r_bit_idx == LAST_IDX);

endmodule

// File: tb/tb_exponent_bit_streamer.sv
// Directed bench for exponent_bit_streamer (REGISTER_SIZE=32, BITS_IN_EXP=64).
module tb_exponent_bit_streamer;

    localparam int RS = 32;
    localparam int BE = 64;

    logic          clk_in;
    logic          rst_in;
    logic [RS-1:0] block_in;
    logic          block_valid_in;
    logic          block_ready_out;
    logic          consumed_bit_in;
    logic          restart_in;
    logic          bit_out;
    logic          bit_valid_out;
    logic [5:0]    bit_idx_out;
    logic          last_bit_out;
    logic          done_out;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int acc_base;

    typedef struct {
        logic consume;
        logic restart;
        logic bvalid;
        int   exp_idx;
        logic exp_bit;
        logic exp_ready;
    } vec_t;

    vec_t vecs[16];

    exponent_bit_streamer #(
        .REGISTER_SIZE(RS),
        .BITS_IN_EXP  (BE)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .block_in       (block_in),
        .block_valid_in (block_valid_in),
        .block_ready_out(block_ready_out),
        .consumed_bit_in(consumed_bit_in),
        .restart_in     (restart_in),
        .bit_out        (bit_out),
        .bit_valid_out  (bit_valid_out),
        .bit_idx_out    (bit_idx_out),
        .last_bit_out   (last_bit_out),
        .done_out       (done_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Handshakes counted mid-cycle where inputs and ready are both settled.
    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && block_valid_in === 1'b1 && block_ready_out === 1'b1) n_acc++;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_block(input logic [31:0] data, input int gap);
        int n;
        block_valid_in = 1'b0;
        repeat (gap) tick();
        block_in       = data;
        block_valid_in = 1'b1;
        n = 0;
        while (block_ready_out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("load_ready", block_ready_out, 1);
        tick();
        block_valid_in = 1'b0;
    endtask

    // Consume all bits back-to-back from idx 0, checking each, then the done cycle.
    task automatic stream_all(input logic [63:0] exp, input string tag);
        for (int i = 0; i < BE; i++) begin
            check($sformatf("%s_idx%0d", tag, i), bit_idx_out, i);
            check($sformatf("%s_bit%0d", tag, i), bit_out, exp[i]);
            check($sformatf("%s_last%0d", tag, i), last_bit_out, (i == BE - 1));
            check($sformatf("%s_valid%0d", tag, i), bit_valid_out, 1);
            consumed_bit_in = 1'b1;
            tick();
        end
        consumed_bit_in = 1'b0;
        check({tag, "_done"}, done_out, 1);
        check({tag, "_done_valid"}, bit_valid_out, 0);
        check({tag, "_done_ready"}, block_ready_out, 0);
        check({tag, "_done_idx"}, bit_idx_out, 0);
    endtask

    initial begin
        // consume, restart, bvalid, idx, bit, ready; pulses alternately 1 and 5 cycles apart
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};

        rst_in          = 1'b0;
        block_in        = '0;
        block_valid_in  = 1'b0;
        consumed_bit_in = 1'b0;
        restart_in      = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_ready", block_ready_out, 1);
        check("rst_valid", bit_valid_out, 0);
        check("rst_bit", bit_out, 0);
        check("rst_last", last_bit_out, 0);
        check("rst_done", done_out, 0);
        check("rst_idx", bit_idx_out, 0);
        rst_in = 1'b1;
        tick();

        // 1. Basic load (valid held high) and stream
        acc_base       = n_acc;
        block_in       = 32'h0000_0005;
        block_valid_in = 1'b1;
        check("t1_ready0", block_ready_out, 1);
        tick();
        block_in = 32'h8000_0000;
        check("t1_ready1", block_ready_out, 1);
        check("t1_valid_mid", bit_valid_out, 0);
        tick();
        block_valid_in = 1'b0;
        check("t1_valid_up", bit_valid_out, 1);
        check("t1_ready_low", block_ready_out, 0);
        check("t1_accepts", n_acc - acc_base, 2);
        stream_all(64'h8000_0000_0000_0005, "t1");
        tick();
        check("t1_done_drop", done_out, 0);
        check("t1_ready_back", block_ready_out, 1);
        check("t1_valid_load", bit_valid_out, 0);

        // 6a. Consume/restart during LOAD are ignored
        consumed_bit_in = 1'b1;
        restart_in      = 1'b1;
        repeat (3) tick();
        consumed_bit_in = 1'b0;
        restart_in      = 1'b0;
        check("t6_load_idx", bit_idx_out, 0);
        check("t6_load_valid", bit_valid_out, 0);
        check("t6_load_ready", block_ready_out, 1);
        check("t6_load_done", done_out, 0);

        // 2. Load with backpressure gaps
        acc_base = n_acc;
        load_block(32'hFFFF_FFFF, 3);
        check("t2_valid_mid", bit_valid_out, 0);
        load_block(32'h0000_0000, 2);
        check("t2_accepts", n_acc - acc_base, 2);
        check("t2_valid_up", bit_valid_out, 1);

        // 3/4/6b. Table: consume spacing, restart, block_valid during STREAM
        acc_base = n_acc;
        for (int v = 0; v < 16; v++) begin
            consumed_bit_in = vecs[v].consume;
            restart_in      = vecs[v].restart;
            block_valid_in  = vecs[v].bvalid;
            block_in        = 32'h1234_5678;
            tick();
            consumed_bit_in = 1'b0;
            restart_in      = 1'b0;
            block_valid_in  = 1'b0;
            check($sformatf("vec%0d_idx", v), bit_idx_out, vecs[v].exp_idx);
            check($sformatf("vec%0d_bit", v), bit_out, vecs[v].exp_bit);
            check($sformatf("vec%0d_valid", v), bit_valid_out, 1);
            check($sformatf("vec%0d_ready", v), block_ready_out, vecs[v].exp_ready);
        end

        // 4. Restart together with consume at idx 10
        consumed_bit_in = 1'b1;
        repeat (9) tick();
        consumed_bit_in = 1'b0;
        check("t4_idx10", bit_idx_out, 10);
        consumed_bit_in = 1'b1;
        restart_in      = 1'b1;
        tick();
        consumed_bit_in = 1'b0;
        restart_in      = 1'b0;
        check("t4_restart_idx", bit_idx_out, 0);
        check("t4_restart_bit", bit_out, 1);

        // Stream with block_valid held high: nothing accepted, data intact
        block_valid_in = 1'b1;
        block_in       = 32'h1234_5678;
        stream_all(64'h0000_0000_FFFF_FFFF, "t2");
        // Replay from DONE
        block_valid_in = 1'b0;
        restart_in     = 1'b1;
        tick();
        restart_in = 1'b0;
        check("t4_replay_valid", bit_valid_out, 1);
        check("t4_replay_ready", block_ready_out, 0);
        check("t4_replay_done", done_out, 0);
        stream_all(64'h0000_0000_FFFF_FFFF, "t4r");
        tick();
        check("t4_back_load", block_ready_out, 1);
        check("t6_no_accepts", n_acc - acc_base, 0);

        // 5. Async reset mid-stream at idx 40
        load_block(32'h0000_0005, 0);
        load_block(32'h8000_0000, 0);
        consumed_bit_in = 1'b1;
        repeat (40) tick();
        consumed_bit_in = 1'b0;
        check("t5_idx40", bit_idx_out, 40);
        #2;
        rst_in = 1'b0;
        #1;
        check("t5_async_valid", bit_valid_out, 0);
        check("t5_async_ready", block_ready_out, 1);
        check("t5_async_idx", bit_idx_out, 0);
        check("t5_async_bit", bit_out, 0);
        tick();
        rst_in = 1'b1;
        tick();
        // Reset mid-load must restart the block index at 0
        load_block(32'hDEAD_BEEF, 0);
        check("t5_partial_valid", bit_valid_out, 0);
        #2;
        rst_in = 1'b0;
        #2;
        rst_in = 1'b1;
        tick();
        load_block(32'h0000_0003, 0);
        check("t5_one_block_valid", bit_valid_out, 0);
        load_block(32'h0000_0000, 0);
        check("t5_reload_valid", bit_valid_out, 1);
        stream_all(64'h0000_0000_0000_0003, "t5");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
